// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the framed serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    st_equal       = 2'b00,
    st_a_less_b    = 2'b01,
    st_a_greater_b = 2'b10
  } cmp_state_t;

  // On the two's-complement sign bit a set 'a' bit means 'a' is the smaller operand.
  function automatic logic sign_adjust(input logic a_gt_b_bit, input logic invert);
    return a_gt_b_bit ^ invert;
  endfunction

endpackage

// File: rtl/serial_comparator_framed_if.sv
// Serial operand stream in, one-hot compare result out.
interface serial_comparator_framed_if;
  logic valid;
  logic first;
  logic msb_first;
  logic a;
  logic b;
  logic res_valid;
  logic a_less_b;
  logic a_eq_b;
  logic a_greater_b;
  logic busy;

  modport master (
    output valid, first, msb_first, a, b,
    input  res_valid, a_less_b, a_eq_b, a_greater_b, busy
  );

  modport slave (
    input  valid, first, msb_first, a, b,
    output res_valid, a_less_b, a_eq_b, a_greater_b, busy
  );
endinterface

// File: rtl/serial_cmp_beat_counter.sv
// Beat position tracker: decodes beat 0 (explicit or implied) and the last beat of a word.
module serial_cmp_beat_counter #(
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 first,
  output logic [$clog2(W)-1:0] beat_c,
  output logic                 is_first_c,
  output logic                 is_last_c
);

  localparam int unsigned CW = $clog2(W);

  logic [CW-1:0] cnt;

  // An asserted first restarts the word even when a word is partially received.
  assign is_first_c = valid & (first | (cnt == '0));
  assign beat_c     = is_first_c ? '0 : cnt;
  assign is_last_c  = valid & (beat_c == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (valid) begin
      if (is_last_c) cnt <= '0;
      else           cnt <= beat_c + CW'(1);
    end
  end

endmodule

// File: rtl/serial_comparator_framed.sv
// Bit-serial magnitude comparator with framing, selectable bit order and optional sign handling.
module serial_comparator_framed
  import serial_cmp_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned SIGNED = 0
) (
  input logic                      clk,
  input logic                      rst,
  serial_comparator_framed_if.slave bus
);

  localparam bit SignedEn = (SIGNED != 0);

  logic [$clog2(W)-1:0] beat;
  logic                 is_first;
  logic                 is_last;

  cmp_state_t st;
  cmp_state_t st_start;
  cmp_state_t st_next;
  logic       msb_mode;
  logic       mode;
  logic       sign_beat;
  logic       a_gt;
  logic       diff;

  serial_cmp_beat_counter #(.W(W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .valid     (bus.valid),
    .first     (bus.first),
    .beat_c    (beat),
    .is_first_c(is_first),
    .is_last_c (is_last)
  );

  // Beat 0 evaluates against a fresh equal state and the live bit-order input.
  assign mode      = is_first ? bus.msb_first : msb_mode;
  assign st_start  = is_first ? st_equal : st;
  assign sign_beat = mode ? (beat == '0) : is_last;
  assign diff      = bus.a ^ bus.b;
  assign a_gt      = sign_adjust(bus.a & ~bus.b, SignedEn & sign_beat);

  // MSB-first locks on the first difference; LSB-first lets the latest difference win.
  always_comb begin
    st_next = st_start;
    if (diff && (!mode || (st_start == st_equal))) begin
      st_next = a_gt ? st_a_greater_b : st_a_less_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st              <= st_equal;
      msb_mode        <= 1'b1;
      bus.res_valid   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.a_less_b    <= 1'b0;
      bus.a_eq_b      <= 1'b0;
      bus.a_greater_b <= 1'b0;
    end else begin
      bus.res_valid <= 1'b0;
      if (bus.valid) begin
        st       <= st_next;
        msb_mode <= mode;
        bus.busy <= ~is_last;
        if (is_last) begin
          bus.res_valid   <= 1'b1;
          bus.a_less_b    <= (st_next == st_a_less_b);
          bus.a_eq_b      <= (st_next == st_equal);
          bus.a_greater_b <= (st_next == st_a_greater_b);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_comparator_framed.sv
// Directed and randomized bench: unsigned and signed W=4 comparators driven by one stream.
module tb_serial_comparator_framed;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_comparator_framed_if u_if ();
  serial_comparator_framed_if s_if ();

  serial_comparator_framed #(.W(W), .SIGNED(0)) u_dut (.clk(clk), .rst(rst), .bus(u_if));
  serial_comparator_framed #(.W(W), .SIGNED(1)) s_dut (.clk(clk), .rst(rst), .bus(s_if));

  int checks   = 0;
  int failures = 0;

  // Reference model: collect the bits of a word, rebuild the integers, compare numerically.
  logic qa[$];
  logic qb[$];
  bit   m_mode   = 1'b1;
  logic exp_rv   = 1'b0;
  logic exp_busy = 1'b0;
  logic [2:0] exp_u = 3'b000;
  logic [2:0] exp_s = 3'b000;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] rel(input int x, input int y);
    if (x < y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete();
    m_mode = 1'b1; exp_rv = 1'b0; exp_busy = 1'b0;
    exp_u = 3'b000; exp_s = 3'b000;
  endtask

  task automatic model_beat(input logic v, input logic f, input logic m, input logic a, input logic b);
    int ua, ub, sa, sb, pos;
    exp_rv = 1'b0;
    if (!v) return;
    if (f || qa.size() == 0) begin
      qa.delete(); qb.delete();
      m_mode = m;
    end
    qa.push_back(a); qb.push_back(b);
    if (qa.size() == W) begin
      ua = 0; ub = 0;
      for (int i = 0; i < W; i++) begin
        pos = m_mode ? (W - 1 - i) : i;
        if (qa[i]) ua += (1 << pos);
        if (qb[i]) ub += (1 << pos);
      end
      sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
      sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
      exp_u = rel(ua, ub);
      exp_s = rel(sa, sb);
      exp_rv = 1'b1;
      qa.delete(); qb.delete();
    end
    exp_busy = (qa.size() != 0);
  endtask

  task automatic check_all();
    check("u_res_valid", u_if.res_valid,   exp_rv);
    check("u_less",      u_if.a_less_b,    exp_u[2]);
    check("u_eq",        u_if.a_eq_b,      exp_u[1]);
    check("u_greater",   u_if.a_greater_b, exp_u[0]);
    check("u_busy",      u_if.busy,        exp_busy);
    check("s_res_valid", s_if.res_valid,   exp_rv);
    check("s_less",      s_if.a_less_b,    exp_s[2]);
    check("s_eq",        s_if.a_eq_b,      exp_s[1]);
    check("s_greater",   s_if.a_greater_b, exp_s[0]);
    check("s_busy",      s_if.busy,        exp_busy);
  endtask

  task automatic cycle(input logic r, input logic v, input logic f, input logic m,
                       input logic a, input logic b);
    @(negedge clk);
    rst = r;
    u_if.valid = v; u_if.first = f; u_if.msb_first = m; u_if.a = a; u_if.b = b;
    s_if.valid = v; s_if.first = f; s_if.msb_first = m; s_if.a = a; s_if.b = b;
    @(posedge clk);
    if (r) model_reset();
    else   model_beat(v, f, m, a, b);
    #1;
    check_all();
  endtask

  task automatic send_bits(input logic [W-1:0] a, input logic [W-1:0] b, input logic msb,
                           input int from, input int to, input logic first_at_from);
    int idx;
    for (int i = from; i <= to; i++) begin
      idx = msb ? (W - 1 - i) : i;
      cycle(1'b0, 1'b1, (i == from) && first_at_from, msb, a[idx], b[idx]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    u_if.valid = 0; u_if.first = 0; u_if.msb_first = 0; u_if.a = 0; u_if.b = 0;
    s_if.valid = 0; s_if.first = 0; s_if.msb_first = 0; s_if.a = 0; s_if.b = 0;

    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_eq_zero", u_if.a_eq_b, 1'b0);

    // Unsigned MSB-first 1010 vs 1001.
    send_bits(4'b1010, 4'b1001, 1'b1, 0, W - 1, 1'b1);
    check("r031_rv", u_if.res_valid, 1'b1);
    check("r031_gt", u_if.a_greater_b, 1'b1);
    idle(1);

    // LSB-first: later difference wins.
    send_bits(4'b0011, 4'b0101, 1'b0, 0, W - 1, 1'b1);
    check("r032_lt", u_if.a_less_b, 1'b1);
    idle(1);

    // Signed -8 vs 7 in both orders, back to back.
    send_bits(4'b1000, 4'b0111, 1'b1, 0, W - 1, 1'b1);
    check("r033_msb_s_lt", s_if.a_less_b, 1'b1);
    check("r033_msb_u_gt", u_if.a_greater_b, 1'b1);
    send_bits(4'b1000, 4'b0111, 1'b0, 0, W - 1, 1'b1);
    check("r033_lsb_s_lt", s_if.a_less_b, 1'b1);
    idle(1);

    // Idle gap mid-word, with a stray first-without-valid.
    send_bits(4'b0110, 4'b0110, 1'b1, 0, 1, 1'b1);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("r034_busy_gap", u_if.busy, 1'b1);
    send_bits(4'b0110, 4'b0110, 1'b1, 2, W - 1, 1'b0);
    check("r034_eq", u_if.a_eq_b, 1'b1);
    idle(1);

    // Abort at beat 2, then a full restarted word.
    send_bits(4'b0000, 4'b1111, 1'b1, 0, 1, 1'b1);
    send_bits(4'b1111, 4'b0000, 1'b1, 0, W - 1, 1'b1);
    check("r035_gt", u_if.a_greater_b, 1'b1);
    idle(1);

    // Reset mid-word, overriding a coincident valid&first.
    send_bits(4'b1111, 4'b0000, 1'b1, 0, 1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("r036_cleared", u_if.a_greater_b, 1'b0);
    send_bits(4'b0001, 4'b0010, 1'b1, 0, W - 1, 1'b0);
    check("r036_lt", u_if.a_less_b, 1'b1);
    idle(1);

    // Randomized traffic: gaps, aborts, mid-word mode flips, occasional reset.
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 75),
            ($urandom_range(0, 99) < 10), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_comparator_framed.md
SERIAL_COMPARATOR_FRAMED -- requirements
Module: serial_comparator_framed

Interface
REQ-001 Parameter W, default 8, word length in bits; legal range 2..32.
REQ-002 Parameter SIGNED, default 0; 1 = operands are two's complement.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 valid  input  1  a/b carry one bit of the current word this cycle (one beat).
REQ-006 first  input  1  qualified by valid; marks beat 0 of a word.
REQ-007 msb_first  input  1  bit order of the word; sampled only on the beat-0 cycle.
REQ-008 a, b  input  1 each  serial operand bits.
REQ-009 res_valid  output  1  one-cycle pulse: result outputs updated.
REQ-010 a_less_b, a_eq_b, a_greater_b  output  1 each  registered, one-hot result of the last completed word.
REQ-011 busy  output  1  high while a word is partially received (beat count 1..W-1).

Function
REQ-012 Beat 0 is either valid&first or the first valid beat after reset or after a word completes; the word completes on beat W-1.
REQ-013 Cycles with valid=0 do not change state, counter or outputs.
REQ-014 Compare FSM states st_equal, st_a_less_b, st_a_greater_b; they are cleared to st_equal at beat 0 before that beat is applied.
REQ-015 MSB-first mode: from st_equal, a!=b moves to less or greater; less and greater are absorbing until the word ends.
REQ-016 LSB-first mode: on every beat with a!=b, the state moves to less or greater per that bit, so the later difference wins.
REQ-017 SIGNED=1: on the sign-bit beat (beat 0 in MSB-first, beat W-1 in LSB-first), a difference is inverted: a=1,b=0 means a less; it otherwise follows the REQ-015/016 rule.
REQ-018 The mode is latched at beat 0 and held for the rest of the word; msb_first changes mid-word are ignored.
REQ-019 On the cycle after beat W-1, res_valid=1 and the three result outputs show the final state, including the effect of beat W-1 (latency 1 cycle).
REQ-020 The result outputs hold their value until the next res_valid; exactly one of them is high after the first result.
REQ-021 valid&first while busy aborts the current word: no res_valid for it, and the beat restarts at 0 with the current bits.
REQ-022 first without valid is ignored.
REQ-023 Back-to-back words with no idle cycle are supported; res_valid of word N coincides with beat 0 of word N+1.
REQ-024 The beat counter wraps W-1 -> 0 and never exceeds W-1.

Reset
REQ-025 rst forces counter=0, FSM=st_equal, latched mode=MSB-first, res_valid=0, busy=0, and all three results=0.
REQ-026 rst mid-word discards the partial word without a res_valid; the next valid beat is beat 0.
REQ-027 rst has priority over valid and first in the same cycle.

Structure
REQ-028 Package serial_cmp_pkg holds the compare-state enum (2-bit) and the sign-inversion helper function.
REQ-029 One sub-module, serial_cmp_beat_counter (parameter W), provides beat index, is_first and is_last; the FSM and output registers live in the top module.
REQ-030 The counter width is $clog2(W); there is no other arithmetic.

Verification (W=4)
REQ-031 Unsigned, MSB-first, a=1010, b=1001, 4 consecutive beats -> res_valid on cycle 5, a_greater_b=1.
REQ-032 Unsigned, LSB-first, a=0011 (bits 1,1,0,0), b=0101 (bits 1,0,1,0) -> a_less_b=1 (the beat-2 difference overrides beat 1).
REQ-033 SIGNED=1, MSB-first, a=1000 (-8), b=0111 (7) -> a_less_b=1; same with LSB-first order -> a_less_b=1.
REQ-034 a=b=0110 with valid low for 3 cycles between beats 1 and 2 -> exactly one res_valid, a_eq_b=1, busy high across the gap.
REQ-035 valid&first at beat 2 of a word, then 3 more beats a=1111, b=0000 -> no res_valid for the aborted word, then one res_valid with a_greater_b=1.
REQ-036 rst at beat 2, then a full word a=0001, b=0010 MSB-first -> the first res_valid after reset shows a_less_b=1, and the outputs are 0 before it.
